display_scan_receiver: RTL and testbench

- Receiving end of the multiplexed 4-digit display bus.
- Samples the time-multiplexed 4-bit digit nibble and its one-hot digit select, glitch-filters both, and demultiplexes them back into four held digit registers.
- Flags completed scan frames and malformed selects.
- Used to loop back and check the display scan path, and to feed downstream logic from a scanned bus.

---
 rtl/display_scan_receiver.sv | 124 ++++++++++++
 tb/tb_display_scan_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_receiver.sv
// rtl/display_scan_receiver.sv - glitch-filtered demux of a scanned 4-digit display bus
// Optional define SCAN_ORDER_CHECK_EN adds the sticky order_error output and scan-order tracking.
module display_scan_receiver #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] scan_data,
    input  logic [3:0] scan_select,
    output logic [3:0] data_3,
    output logic [3:0] data_2,
    output logic [3:0] data_1,
    output logic [3:0] data_0,
    output logic [3:0] digit_valid,
    output logic       frame_valid,
    output logic       select_error
`ifdef SCAN_ORDER_CHECK_EN
    ,
    output logic       order_error
`endif
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STABLE_CYCLES);

    logic [7:0]       s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] run_q, run_d;
    logic             armed_q, armed_d;
    logic             change, arm, capture;
    logic [3:0]       cap_sel, cap_nib;
    logic             one_hot, multi_hot;
    logic [3:0]       data_q [4];
    logic [3:0]       digit_valid_q;
    logic [3:0]       mask_q, mask_d;
    logic             frame_q, frame_d;
    logic             select_error_q;

    always_comb begin
        change    = (s2_q != s3_q);
        cap_sel   = s2_q[7:4];
        cap_nib   = s2_q[3:0];
        run_d     = change ? CNT_W'(1) : ((run_q == RUN_MAX) ? run_q : run_q + 1'b1);
        // A change re-arms in the same cycle so STABLE_CYCLES=1 captures immediately.
        arm       = change | armed_q;
        capture   = arm && (run_d == RUN_MAX);
        armed_d   = arm && !capture;
        multi_hot = ((cap_sel & (cap_sel - 4'd1)) != 4'd0);
        one_hot   = (cap_sel != 4'd0) && !multi_hot;
        mask_d    = mask_q;
        frame_d   = 1'b0;
        if (capture && one_hot) begin
            mask_d = mask_q | cap_sel;
            if (mask_d == 4'hF) begin
                frame_d = 1'b1;
                mask_d  = 4'h0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q           <= 8'h00;
            s2_q           <= 8'h00;
            s3_q           <= 8'h00;
            run_q          <= '0;
            armed_q        <= 1'b0;
            digit_valid_q  <= 4'h0;
            mask_q         <= 4'h0;
            frame_q        <= 1'b0;
            select_error_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= 4'h0;
            end
        end else begin
            s1_q    <= {scan_select, scan_data};
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            run_q   <= run_d;
            armed_q <= armed_d;
            mask_q  <= mask_d;
            frame_q <= frame_d;
            if (capture && multi_hot) begin
                select_error_q <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (capture && one_hot && cap_sel[i]) begin
                    data_q[i]        <= cap_nib;
                    digit_valid_q[i] <= 1'b1;
                end
            end
        end
    end

`ifdef SCAN_ORDER_CHECK_EN
    logic [3:0] last_q;
    logic       has_last_q;
    logic       order_error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q        <= 4'h0;
            has_last_q    <= 1'b0;
            order_error_q <= 1'b0;
        end else if (capture && one_hot) begin
            last_q     <= cap_sel;
            has_last_q <= 1'b1;
            if (has_last_q && (cap_sel != {last_q[2:0], last_q[3]})) begin
                order_error_q <= 1'b1;
            end
        end
    end

    assign order_error = order_error_q;
`endif

    assign data_3       = data_q[3];
    assign data_2       = data_q[2];
    assign data_1       = data_q[1];
    assign data_0       = data_q[0];
    assign digit_valid  = digit_valid_q;
    assign frame_valid  = frame_q;
    assign select_error = select_error_q;

endmodule

// File: tb/tb_display_scan_receiver.sv
// tb/tb_display_scan_receiver.sv - randomized bench for display_scan_receiver with a window-based reference model
module tb_display_scan_receiver;

    localparam int S = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] scan_data = 4'h0;
    logic [3:0] scan_select = 4'h0;
    logic [3:0] data_3, data_2, data_1, data_0;
    logic [3:0] digit_valid;
    logic       frame_valid;
    logic       select_error;
`ifdef SCAN_ORDER_CHECK_EN
    logic       order_error;
`endif

    display_scan_receiver #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .scan_data   (scan_data),
        .scan_select (scan_select),
        .data_3      (data_3),
        .data_2      (data_2),
        .data_1      (data_1),
        .data_0      (data_0),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .select_error(select_error)
`ifdef SCAN_ORDER_CHECK_EN
        ,
        .order_error (order_error)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: sampled-input history, newest first; a capture fires when the S samples
    // ending two edges ago agree and differ from the sample just before them.
    logic [7:0] h [S+2];
    logic [3:0] m_data [4];
    logic [3:0] m_dv, m_mask;
    logic       m_fv, m_serr, m_oerr;
    int         m_last_idx;

    task automatic model_edge(input logic rst, input logic [7:0] in);
        bit         stable;
        logic [3:0] sel;
        int         idx;
        m_fv = 1'b0;
        if (rst) begin
            for (int i = 0; i < S + 2; i++) h[i] = 8'h00;
            for (int i = 0; i < 4; i++) m_data[i] = 4'h0;
            m_dv = 0; m_mask = 0; m_serr = 0; m_oerr = 0; m_last_idx = -1;
            return;
        end
        stable = 1;
        for (int i = 2; i <= S; i++) if (h[i] != h[1]) stable = 0;
        if (h[S+1] == h[1]) stable = 0;
        if (stable) begin
            sel = h[1][7:4];
            if ($countones(sel) == 1) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
                m_data[idx] = h[1][3:0];
                m_dv[idx]   = 1'b1;
                m_mask[idx] = 1'b1;
                if (m_mask == 4'hF) begin
                    m_fv   = 1'b1;
                    m_mask = 4'h0;
                end
                if (m_last_idx >= 0 && idx != (m_last_idx + 1) % 4) m_oerr = 1'b1;
                m_last_idx = idx;
            end else if ($countones(sel) > 1) begin
                m_serr = 1'b1;
            end
        end
        for (int i = S + 1; i > 0; i--) h[i] = h[i-1];
        h[0] = in;
    endtask

    task automatic compare_all();
        check_eq("data_0", data_0, m_data[0]);
        check_eq("data_1", data_1, m_data[1]);
        check_eq("data_2", data_2, m_data[2]);
        check_eq("data_3", data_3, m_data[3]);
        check_eq("digit_valid", digit_valid, m_dv);
        check_eq("frame_valid", frame_valid, m_fv);
        check_eq("select_error", select_error, m_serr);
`ifdef SCAN_ORDER_CHECK_EN
        check_eq("order_error", order_error, m_oerr);
`endif
    endtask

    task automatic cycle(input logic rst, input logic [3:0] sel, input logic [3:0] dat);
        @(negedge clock);
        reset       = rst;
        scan_select = sel;
        scan_data   = dat;
        @(posedge clock);
        model_edge(rst, {sel, dat});
        #1;
        if (frame_valid === 1'b1) fv_count++;
        compare_all();
    endtask

    task automatic hold(input logic [3:0] sel, input logic [3:0] dat, input int n);
        repeat (n) cycle(1'b0, sel, dat);
    endtask

    task automatic do_reset();
        cycle(1'b1, 4'h0, 4'h0);
    endtask

    initial begin
        logic [3:0] sel;
        int         kind, rot;

        do_reset();
        do_reset();
        check_eq("rst_data", {data_3, data_2, data_1, data_0}, 16'h0000);
        check_eq("rst_flags", {digit_valid, frame_valid, select_error}, 6'b0);

        // single digit, exact latency
        hold(4'b0001, 4'h7, 5);
        check_eq("p1_early", data_0, 4'h0);
        hold(4'b0001, 4'h7, 1);
        check_eq("p1_edge6", data_0, 4'h7);
        hold(4'b0001, 4'h7, 4);
        check_eq("p1_dv", digit_valid, 4'b0001);

        // full frame
        fv_count = 0;
        hold(4'b0001, 4'h1, 8);
        hold(4'b0010, 4'h2, 8);
        hold(4'b0100, 4'h3, 8);
        hold(4'b1000, 4'h4, 8);
        check_eq("p2_frames", fv_count, 1);
        check_eq("p2_data", {data_3, data_2, data_1, data_0}, 16'h4321);

        // glitch rejection
        do_reset();
        hold(4'b0100, 4'h9, 3);
        hold(4'b0000, 4'h0, 8);
        check_eq("p3_data2", data_2, 4'h0);
        check_eq("p3_dv", digit_valid, 4'h0);

        // multi-hot select
        hold(4'b0110, 4'h5, 8);
        check_eq("p4_serr", select_error, 1'b1);
        hold(4'b0001, 4'hA, 8);
        check_eq("p4_data0", data_0, 4'hA);
        check_eq("p4_serr_sticky", select_error, 1'b1);

        // reset mid-frame
        hold(4'b0001, 4'h1, 8);
        hold(4'b0010, 4'h2, 8);
        do_reset();
        check_eq("p5_rst", {data_3, data_2, data_1, data_0, digit_valid}, 20'h0);
        fv_count = 0;
        hold(4'b0001, 4'h5, 8);
        hold(4'b0010, 4'h6, 8);
        hold(4'b0100, 4'h7, 8);
        check_eq("p5_no_early_frame", fv_count, 0);
        hold(4'b1000, 4'h8, 8);
        check_eq("p5_frames", fv_count, 1);

        // out-of-order capture
        do_reset();
        hold(4'b0001, 4'h1, 8);
        hold(4'b0100, 4'h5, 8);
        check_eq("p6_data2", data_2, 4'h5);
`ifdef SCAN_ORDER_CHECK_EN
        check_eq("p6_order_error", order_error, 1'b1);
`endif

        // randomized scanning with blanking, glitches, multi-hot and resets
        rot = 0;
        for (int seg = 0; seg < 500; seg++) begin
            kind = $urandom_range(0, 99);
            if (kind < 3) begin
                do_reset();
                continue;
            end else if (kind < 45) begin
                sel = 4'b0001 << rot;
                rot = (rot + 1) % 4;
            end else if (kind < 70) begin
                sel = 4'b0001 << $urandom_range(0, 3);
            end else if (kind < 90) begin
                sel = 4'b0000;
            end else begin
                do sel = 4'($urandom_range(0, 15)); while ($countones(sel) < 2);
            end
            hold(sel, 4'($urandom_range(0, 15)), $urandom_range(1, 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
